// File: rtl/normaliser_pkg.sv
// Shared types for the normalisation stage.
// Result flags travel together through stage 2.
package normaliser_pkg;

    typedef struct packed {
        logic zero;
        logic denorm;
    } norm_flags_t;

endpackage

// File: rtl/norm_lzc.sv
// Combinational leading-zero counter; count == WIDTH when the input is all zeros.
module norm_lzc #(
    parameter int WIDTH = 24,
    localparam int SHW = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] a,
    output logic [SHW-1:0]   count,
    output logic             all_zero
);

    // Ascending scan: the highest set bit is the last one to write count.
    always_comb begin
        count = SHW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i]) begin
                count = SHW'(WIDTH - 1 - i);
            end
        end
    end

    assign all_zero = ~|a;

endmodule

// File: rtl/normaliser.sv
// Two-stage normaliser: stage 1 registers the mantissa with its leading-zero count,
// stage 2 left-justifies it, limited by the exponent headroom above EXP_MIN.
// Handshake: a transfer occurs on a side when valid & ready are both high at a
// rising edge; valid holds its data until accepted and ready may depend on downstream.
module normaliser
    import normaliser_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter int EXP_WIDTH = 8,
    parameter int EXP_MIN   = -126
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_m,
    output logic [EXP_WIDTH-1:0] out_e,
    output logic                 out_zero,
    output logic                 out_denorm,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int SHW = $clog2(WIDTH + 1);
    localparam int HW  = EXP_WIDTH + 1;
    localparam int CW  = (SHW > HW) ? SHW : HW;

    logic                 s1_valid_q;
    logic [WIDTH-1:0]     s1_m_q;
    logic [EXP_WIDTH-1:0] s1_e_q;
    logic [SHW-1:0]       s1_lzc_q;
    logic                 s1_zero_q;

    logic                 out_valid_q;
    logic [WIDTH-1:0]     out_m_q, out_m_d;
    logic [EXP_WIDTH-1:0] out_e_q, out_e_d;
    norm_flags_t          out_flags_q, out_flags_d;

    logic [SHW-1:0]       lzc;
    logic                 lzc_zero;
    logic                 s1_load;
    logic                 s2_load;

    logic signed [HW-1:0] headroom;
    logic [CW-1:0]        lzc_ext;
    logic [CW-1:0]        head_ext;
    logic [CW-1:0]        shift_amt;
    logic [WIDTH-1:0]     shifted_m;

    norm_lzc #(.WIDTH(WIDTH)) u_lzc (
        .a        (in_m),
        .count    (lzc),
        .all_zero (lzc_zero)
    );

    assign s2_load  = !out_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_m_q     <= '0;
            s1_e_q     <= '0;
            s1_lzc_q   <= '0;
            s1_zero_q  <= 1'b0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_m_q    <= in_m;
                s1_e_q    <= in_e;
                s1_lzc_q  <= lzc;
                s1_zero_q <= lzc_zero;
            end
        end
    end

    // Headroom is computed one bit wider so e - EXP_MIN never overflows.
    assign headroom = HW'($signed(s1_e_q)) - HW'(EXP_MIN);
    assign lzc_ext  = CW'(s1_lzc_q);
    assign head_ext = CW'($unsigned(headroom));

    always_comb begin
        shift_amt = '0;
        if (headroom > 0) begin
            shift_amt = (lzc_ext < head_ext) ? lzc_ext : head_ext;
        end
    end

    assign shifted_m = s1_m_q << shift_amt;

    always_comb begin
        out_m_d            = shifted_m;
        out_e_d            = s1_e_q - EXP_WIDTH'(shift_amt);
        out_flags_d.zero   = 1'b0;
        out_flags_d.denorm = !shifted_m[WIDTH-1];
        if (s1_zero_q) begin
            out_m_d            = '0;
            out_e_d            = EXP_WIDTH'(EXP_MIN);
            out_flags_d.zero   = 1'b1;
            out_flags_d.denorm = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_m_q     <= '0;
            out_e_q     <= '0;
            out_flags_q <= '0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_m_q     <= out_m_d;
                out_e_q     <= out_e_d;
                out_flags_q <= out_flags_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_m      = out_m_q;
    assign out_e      = out_e_q;
    assign out_zero   = out_flags_q.zero;
    assign out_denorm = out_flags_q.denorm;

endmodule

// File: tb/tb_normaliser.sv
// Bench for normaliser (WIDTH=8, EXP_WIDTH=8, EXP_MIN=-126): directed cases,
// stall/reset scenarios and a random sweep against an arithmetic reference model.
module tb_normaliser;

    localparam int W  = 8;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_m;
    logic [EW-1:0] in_e;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out_m;
    logic [EW-1:0] out_e;
    logic          out_zero;
    logic          out_denorm;
    logic          out_valid;
    logic          out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];
    logic        in_xfer;
    logic        last_in_ready;

    normaliser #(.WIDTH(W), .EXP_WIDTH(EW), .EXP_MIN(-126)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_m       (in_m),
        .in_e       (in_e),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_m      (out_m),
        .out_e      (out_e),
        .out_zero   (out_zero),
        .out_denorm (out_denorm),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    // Reference: shift left until normalised, but never below exponent -126.
    function automatic logic [17:0] model(input logic [7:0] m, input logic [7:0] e);
        int lz, h, sh, ev;
        logic [7:0] mo;
        logic [7:0] emin;
        emin = 8'(-126);
        if (m == 8'h00) return {8'h00, emin, 1'b1, 1'b0};
        lz = 0;
        while (m[7 - lz] == 1'b0) lz++;
        h  = int'($signed(e)) + 126;
        sh = (h <= 0) ? 0 : ((lz < h) ? lz : h);
        mo = m << sh;
        ev = int'($signed(e)) - sh;
        return {mo, 8'(ev), 1'b0, ~mo[7]};
    endfunction

    // One clock: settle, record any transfers on either side, advance.
    task automatic drive_cycle();
        #1;
        last_in_ready = in_ready;
        in_xfer = in_valid && in_ready && !rst;
        if (in_xfer) exp_q.push_back(model(in_m, in_e));
        if (out_valid && out_ready && !rst)
            obs_q.push_back({out_m, out_e, out_zero, out_denorm});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_m = '0; in_e = '0; out_ready = 1'b1;
        repeat (3) drive_cycle();
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_checks++;
        if ({out_m, out_e, out_zero, out_denorm} !== 18'h0)
            begin n_fail++; $display("FAIL reset_outputs got m=%h e=%h z=%b d=%b exp all 0", out_m, out_e, out_zero, out_denorm); end
    endtask

    task automatic test_directed();
        logic [7:0]  dm [4] = '{8'h10, 8'h01, 8'h00, 8'h80};
        logic [7:0]  de [4] = '{8'd5, 8'(-124), 8'd3, 8'(-126)};
        logic [17:0] dx [4] = '{{8'h80, 8'd2, 1'b0, 1'b0},
                                {8'h04, 8'(-126), 1'b0, 1'b1},
                                {8'h00, 8'(-126), 1'b1, 1'b0},
                                {8'h80, 8'(-126), 1'b0, 1'b0}};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_m = dm[i]; in_e = de[i];
            drive_cycle();
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early got out_valid=%b exp 0", i, out_valid); end
            drive_cycle();
            n_checks++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_latency got out_valid=%b exp 1", i, out_valid); end
            n_checks++;
            if ({out_m, out_e, out_zero, out_denorm} !== dx[i])
                begin n_fail++; $display("FAIL dir%0d_value got %h exp %h", i, {out_m, out_e, out_zero, out_denorm}, dx[i]); end
            drive_cycle();
        end
        n_checks++;
        if (obs_q.size() != exp_q.size())
            begin n_fail++; $display("FAIL dir_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [17:0] o, x;
            o = obs_q.pop_front(); x = exp_q.pop_front();
            n_checks++;
            if (o !== x) begin n_fail++; $display("FAIL dir_model got %h exp %h", o, x); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_stall();
        int sent = 0, stall = 0, cyc = 0;
        bit seen_valid = 0, seen_block = 0;
        logic [17:0] snap;
        out_ready = 1'b1;
        while ((sent < 4 || obs_q.size() < 4) && cyc < 60) begin
            if (out_valid && !seen_valid) begin seen_valid = 1; stall = 3; end
            out_ready = (stall == 0);
            if (sent < 4 && !in_valid) begin
                in_valid = 1'b1; in_m = 8'($urandom_range(1, 255)); in_e = 8'($urandom_range(0, 255));
            end
            if (stall == 3) snap = {out_m, out_e, out_zero, out_denorm};
            if (stall > 0 && stall < 3) begin
                n_checks++;
                if ({out_m, out_e, out_zero, out_denorm, out_valid} !== {snap, 1'b1})
                    begin n_fail++; $display("FAIL stall_hold got %h exp %h", {out_m, out_e, out_zero, out_denorm}, snap); end
            end
            drive_cycle();
            if (!last_in_ready) seen_block = 1;
            if (in_xfer) begin sent++; if (sent == 4) in_valid = 1'b0; else in_valid = 1'b0; end
            if (stall > 0) stall--;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (!seen_block) begin n_fail++; $display("FAIL stall_backpressure got in_ready never 0 exp 0 while full"); end
        n_checks++;
        if (obs_q.size() != 4 || exp_q.size() != 4)
            begin n_fail++; $display("FAIL stall_count got %0d out %0d in exp 4", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [17:0] o, x;
            o = obs_q.pop_front(); x = exp_q.pop_front();
            n_checks++;
            if (o !== x) begin n_fail++; $display("FAIL stall_order got %h exp %h", o, x); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_m = 8'h03 << i; in_e = 8'd10;
            drive_cycle();
        end
        rst = 1'b1; in_valid = 1'b1; in_m = 8'h55; in_e = 8'd1;
        drive_cycle();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        exp_q.delete(); obs_q.delete();
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstfl_out_valid got %b exp 0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstfl_in_ready got %b exp 1", in_ready); end
        n_checks++;
        if ({out_m, out_e} !== 16'h0) begin n_fail++; $display("FAIL rstfl_outputs got m=%h e=%h exp 0 0", out_m, out_e); end
        in_valid = 1'b1; in_m = 8'h20; in_e = 8'd0;
        drive_cycle();
        in_valid = 1'b0;
        drive_cycle();
        n_checks++;
        if ({out_valid, out_m, out_e, out_zero, out_denorm} !== {1'b1, 8'h80, 8'(-2), 1'b0, 1'b0})
            begin n_fail++; $display("FAIL rstfl_next got v=%b m=%h e=%h exp v=1 m=80 e=fe", out_valid, out_m, out_e); end
        drive_cycle();
        n_checks++;
        if (obs_q.size() != 1) begin n_fail++; $display("FAIL rstfl_discard got %0d outputs exp 1", obs_q.size()); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int n = 400, sent = 0, cyc = 0;
        in_valid = 1'b0;
        while ((sent < n || obs_q.size() < n) && cyc < 5000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < n && $urandom_range(0, 4) != 0) begin
                in_valid = 1'b1;
                case ($urandom_range(0, 3))
                    0: in_m = 8'h00;
                    1: in_m = 8'(1 << $urandom_range(0, 7));
                    default: in_m = 8'($urandom_range(0, 255));
                endcase
                in_e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(128, 136)) : 8'($urandom_range(0, 255));
            end
            drive_cycle();
            if (in_xfer) begin sent++; in_valid = 1'b0; end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (obs_q.size() != n || exp_q.size() != n)
            begin n_fail++; $display("FAIL rand_count got %0d out %0d in exp %0d", obs_q.size(), exp_q.size(), n); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [17:0] o, x;
            o = obs_q.pop_front(); x = exp_q.pop_front();
            n_checks++;
            if (o !== x) begin n_fail++; $display("FAIL rand_item got %h exp %h", o, x); end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_m = '0; in_e = '0; out_ready = 1'b1;
        test_reset();
        test_directed();
        test_stall();
        test_reset_inflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
